// File: rtl/mac_seq_ctrl.sv
// Job sequencer for the MAC wrapper port: cfg pulse, enable/feed window, drain, read, result handshake.
// Read lands N+DRAIN+4 cycles after job_start (no bubbles); result is held until res_ready.
module mac_seq_ctrl #(
  parameter int LEN_W = 8,
  parameter int DRAIN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             job_start,
  input  logic             job_mode,
  input  logic [LEN_W-1:0] job_len,
  output logic             job_busy,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  output logic             mac_enable,
  output logic             mac_valid,
  output logic             mac_read,
  output logic             mac_cfg,
  output logic             mac_mode,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  input  logic [15:0]      mac_out,
  input  logic             mac_error,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic             res_error
);

  localparam int DC_W = $clog2(DRAIN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_ARM, S_FEED, S_DRAIN, S_READ, S_RESULT
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, cnt_q;
  logic [DC_W-1:0]  dcnt_q;
  logic             mode_q, valid_q, err_q;
  logic [15:0]      a_q, b_q, res_q;
  logic             op_acc;
  logic             err_window;

  assign op_acc     = (state_q == S_FEED) && op_valid;
  assign err_window = (state_q == S_ARM) || (state_q == S_FEED) ||
                      (state_q == S_DRAIN) || (state_q == S_READ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    job_busy   = (state_q != S_IDLE);
    mac_cfg    = (state_q == S_CFG);
    mac_enable = err_window;
    mac_read   = (state_q == S_READ);
    op_ready   = (state_q == S_FEED);
    res_valid  = (state_q == S_RESULT);
    case (state_q)
      S_IDLE:   if (job_start) state_d = S_CFG;
      S_CFG:    state_d = S_ARM;
      S_ARM:    state_d = (len_q == '0) ? S_DRAIN : S_FEED;
      S_FEED:   if (op_acc && (cnt_q == len_q - LEN_W'(1))) state_d = S_DRAIN;
      S_DRAIN:  if (dcnt_q == DC_W'(DRAIN)) state_d = S_READ;
      S_READ:   state_d = S_RESULT;
      S_RESULT: if (res_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q   <= '0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      // mode is latched at start so it is already on mac_mode during the CFG cycle
      if (state_q == S_IDLE && job_start) begin
        len_q  <= job_len;
        mode_q <= job_mode;
      end
      if (state_q == S_CFG) begin
        err_q <= 1'b0;
      end else if (err_window) begin
        err_q <= err_q | mac_error;
      end
      if (state_q == S_CFG) begin
        cnt_q <= '0;
      end else if (op_acc) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
      if (op_acc) begin
        a_q <= op_a;
        b_q <= op_b;
      end
      valid_q <= op_acc;
      dcnt_q  <= (state_q == S_DRAIN) ? dcnt_q + DC_W'(1) : '0;
      if (state_q == S_READ) begin
        res_q <= mac_out;
      end
    end
  end

  assign mac_mode  = mode_q;
  assign mac_valid = valid_q;
  assign mac_a     = a_q;
  assign mac_b     = b_q;
  assign res_data  = res_q;
  assign res_error = err_q;

endmodule
